shift_pipe_stage: RTL and testbench

SHIFT_PIPE_STAGE -- requirements
Module: shift_pipe_stage

---
 rtl/shift_pipe_stage_pkg.sv | 34 +++
 rtl/shift_pipe_stage_if.sv | 28 ++
 rtl/shift_pipe_stage_shifter.sv | 22 ++
 rtl/shift_pipe_stage.sv | 101 ++++++++++
 tb/tb_shift_pipe_stage.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pipe_stage_pkg.sv
// Shared shifter constants: op encodings, datapath widths, result bundle and
// the shifted-out-bit detector used by the pipe stage and the ALU decoder.
package shift_pipe_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_SLL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_SRL  = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              neg;
    logic              lost;
  } shift_res_t;

  // Masks select the top n bits (SLL) or bottom n bits (SRL); n = 0 gives an empty mask.
  function automatic logic shift_lost(shift_op_e op, logic [DATA_W-1:0] a, logic [AMT_W-1:0] n);
    logic [DATA_W-1:0] mask;
    mask = '0;
    case (op)
      OP_SLL:  mask = ~({DATA_W{1'b1}} >> n);
      OP_SRL:  mask = ~({DATA_W{1'b1}} << n);
      default: mask = '0;
    endcase
    return |(a & mask);
  endfunction

endpackage

// File: rtl/shift_pipe_stage_if.sv
// Request/result handshake bundle for the shift pipe stage.
// master = producer/consumer side, slave = the stage itself.
interface shift_pipe_stage_if;
  import shift_pipe_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [1:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_res;
  logic              out_zero;
  logic              out_neg;
  logic              out_lost;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_res, out_zero, out_neg, out_lost
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_res, out_zero, out_neg, out_lost
  );

endinterface

// File: rtl/shift_pipe_stage_shifter.sv
// Combinational barrel shifter; {ctl1,ctl0} selects pass/SLL/SRA/SRL.
module Shifter
  import shift_pipe_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              ctl0_i,
  input  logic              ctl1_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    case (shift_op_e'({ctl1_i, ctl0_i}))
      OP_SLL:  y_o = a_i << b_i;
      OP_SRA:  y_o = $signed(a_i) >>> b_i;
      OP_SRL:  y_o = a_i >> b_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/shift_pipe_stage.sv
// Two-register shift pipeline: S1 holds operands, S2 holds the shifted result
// and flags, with valid/ready flow control on both sides.
module shift_pipe_stage
  import shift_pipe_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  shift_pipe_stage_if.slave bus,
  output logic [CNT_W-1:0]  done_cnt
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [AMT_W-1:0]  s1_amt_q, s1_amt_d;
  shift_op_e         s1_op_q, s1_op_d;
  logic              s2_valid_q, s2_valid_d;
  shift_res_t        s2_q, s2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s2_take, s2_load, in_ready_w, accept;
  logic [1:0]        op_bits;
  logic [DATA_W-1:0] shift_y;
  logic              unused_b_hi;

  assign unused_b_hi = ^bus.in_b[DATA_W-1:AMT_W];

  assign s2_take    = s2_valid_q & bus.out_ready;
  assign s2_load    = s1_valid_q & (~s2_valid_q | s2_take);
  assign in_ready_w = ~s1_valid_q | s2_load;
  assign accept     = bus.in_valid & in_ready_w;
  assign op_bits    = s1_op_q;

  Shifter u_shifter (
    .a_i    (s1_a_q),
    .b_i    ({{(DATA_W-AMT_W){1'b0}}, s1_amt_q}),
    .ctl0_i (op_bits[0]),
    .ctl1_i (op_bits[1]),
    .y_o    (shift_y)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_amt_d   = s1_amt_q;
    s1_op_d    = s1_op_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = bus.in_a;
      s1_amt_d   = bus.in_b[AMT_W-1:0];
      s1_op_d    = shift_op_e'(bus.in_op);
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_d.res   = shift_y;
      s2_d.zero  = (shift_y == '0);
      s2_d.neg   = shift_y[DATA_W-1];
      s2_d.lost  = shift_lost(s1_op_q, s1_a_q, s1_amt_q);
    end else if (s2_take) begin
      s2_valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (s2_take) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_amt_q   <= '0;
      s1_op_q    <= OP_PASS;
      s2_valid_q <= 1'b0;
      s2_q       <= '{res: '0, zero: 1'b1, neg: 1'b0, lost: 1'b0};
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_amt_q   <= s1_amt_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_res   = s2_q.res;
  assign bus.out_zero  = s2_q.zero;
  assign bus.out_neg   = s2_q.neg;
  assign bus.out_lost  = s2_q.lost;
  assign done_cnt      = cnt_q;

endmodule

// File: tb/tb_shift_pipe_stage.sv
// Scoreboard bench for shift_pipe_stage: expectations queued at input accept,
// compared at each output handshake.
module tb_shift_pipe_stage;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] done_cnt;

  shift_pipe_stage_if ifc ();

  shift_pipe_stage #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifc),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        lost;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e, mon_got;

  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    exp_t        e;
    int          n;
    logic [31:0] r, t;
    logic        l;
    n = int'(b[4:0]);
    r = a;
    l = 1'b0;
    case (op)
      2'b01: begin
        r = a << n;
        t = a >> (32 - n);
        l = (n != 0) && (t != 0);
      end
      2'b10: r = $signed(a) >>> n;
      2'b11: begin
        r = a >> n;
        t = a << (32 - n);
        l = (n != 0) && (t != 0);
      end
      default: r = a;
    endcase
    e.res  = r;
    e.zero = (r == 32'h0);
    e.neg  = r[31];
    e.lost = l;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && ifc.out_valid && ifc.out_ready) begin
      mon_got = {ifc.out_res, ifc.out_zero, ifc.out_neg, ifc.out_lost};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got res=%h zero=%b neg=%b lost=%b, required no output",
                 mon_got.res, mon_got.zero, mon_got.neg, mon_got.lost);
      end else begin
        mon_e = sb.pop_front();
        if (mon_got !== mon_e) begin
          errors++;
          $display("FAIL result: got res=%h zero=%b neg=%b lost=%b, required res=%h zero=%b neg=%b lost=%b",
                   mon_got.res, mon_got.zero, mon_got.neg, mon_got.lost,
                   mon_e.res, mon_e.zero, mon_e.neg, mon_e.lost);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input exp_t e, output int unsigned stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    ifc.in_valid = 1'b1;
    ifc.in_a     = a;
    ifc.in_b     = b;
    ifc.in_op    = op;
    while (!done) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 100) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", stalls);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", ifc.out_valid); end
    checks++; if (done_cnt !== '0) begin errors++; $display("FAIL rst_done_cnt: got %0d, required 0", done_cnt); end
    checks++; if (ifc.out_res !== 32'h0) begin errors++; $display("FAIL rst_out_res: got %h, required 0", ifc.out_res); end
    checks++; if (ifc.out_zero !== 1'b1) begin errors++; $display("FAIL rst_out_zero: got %b, required 1", ifc.out_zero); end
    checks++; if (ifc.out_neg !== 1'b0) begin errors++; $display("FAIL rst_out_neg: got %b, required 0", ifc.out_neg); end
    checks++; if (ifc.out_lost !== 1'b0) begin errors++; $display("FAIL rst_out_lost: got %b, required 0", ifc.out_lost); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, required 1", ifc.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    int unsigned st;
    ifc.out_ready = 1'b1;
    send(32'h0000_0001, 32'd31, 2'b01, '{res: 32'h8000_0000, zero: 1'b0, neg: 1'b1, lost: 1'b0}, st);
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL latency_1cyc: out_valid got %b, required 0", ifc.out_valid); end
    @(posedge clk);
    #1;
    checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL latency_2cyc: out_valid got %b, required 1", ifc.out_valid); end
    drain();
  endtask

  task automatic test_directed();
    logic [31:0] va [7] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0000_0001,
                            32'hDEAD_BEEF, 32'h8000_000F, 32'h0000_0001};
    logic [31:0] vb [7] = '{32'd7, 32'd7, 32'd1, 32'd1, 32'h0000_001F, 32'd4, 32'hFFFF_FFE1};
    logic [1:0]  vo [7] = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
    exp_t        ve [7] = '{'{res: 32'hFF00_0000, zero: 1'b0, neg: 1'b1, lost: 1'b0},
                            '{res: 32'h0100_0000, zero: 1'b0, neg: 1'b0, lost: 1'b0},
                            '{res: 32'hFFFF_FFFC, zero: 1'b0, neg: 1'b1, lost: 1'b1},
                            '{res: 32'h0000_0000, zero: 1'b1, neg: 1'b0, lost: 1'b1},
                            '{res: 32'hDEAD_BEEF, zero: 1'b0, neg: 1'b1, lost: 1'b0},
                            '{res: 32'hF800_0000, zero: 1'b0, neg: 1'b1, lost: 1'b0},
                            '{res: 32'h0000_0002, zero: 1'b0, neg: 1'b0, lost: 1'b0}};
    int unsigned st;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(va[i], vb[i], vo[i], ve[i], st);
    drain();
  endtask

  task automatic test_throughput();
    int unsigned st, total;
    logic [31:0] a, b;
    logic [1:0]  op;
    total = 0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(0, 3));
      send(a, b, op, model(a, b, op), st);
      total += st;
    end
    checks++; if (total != 0) begin errors++; $display("FAIL throughput_stalls: got %0d stall cycles, required 0", total); end
    drain();
  endtask

  task automatic test_random_backpressure();
    bit          stop;
    int unsigned st;
    logic [31:0] a, b;
    logic [1:0]  op;
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          a  = $urandom;
          b  = $urandom;
          op = 2'($urandom_range(0, 3));
          send(a, b, op, model(a, b, op), st);
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          ifc.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ifc.out_ready = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4] = '{32'h1234_5678, 32'h8000_0001, 32'h0000_00F0, 32'hCAFE_F00D};
    logic [31:0] vb [4] = '{32'd4, 32'd31, 32'd4, 32'd0};
    logic [1:0]  vo [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    exp_t        e0;
    int unsigned st0, st1, st2, st3;
    do_reset();
    ifc.out_ready = 1'b0;
    e0 = model(va[0], vb[0], vo[0]);
    send(va[0], vb[0], vo[0], e0, st0);
    send(va[1], vb[1], vo[1], model(va[1], vb[1], vo[1]), st1);
    checks++; if (st0 + st1 != 0) begin errors++; $display("FAIL b2b_first_two: got %0d stalls, required 0", st0 + st1); end
    fork
      begin
        send(va[2], vb[2], vo[2], model(va[2], vb[2], vo[2]), st2);
        send(va[3], vb[3], vo[3], model(va[3], vb[3], vo[3]), st3);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready: got %b, required 0", ifc.in_ready); end
          checks++;
          if (ifc.out_valid !== 1'b1 || {ifc.out_res, ifc.out_zero, ifc.out_neg, ifc.out_lost} !== e0) begin
            errors++;
            $display("FAIL b2b_hold: got valid=%b res=%h, required valid=1 res=%h", ifc.out_valid, ifc.out_res, e0.res);
          end
        end
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_simul_in_ready: got %b, required 1", ifc.in_ready); end
      end
    join
    drain();
    checks++; if (done_cnt !== CNT_W'(4)) begin errors++; $display("FAIL b2b_done_cnt: got %0d, required 4", done_cnt); end
  endtask

  task automatic test_reset_midflight();
    int unsigned st;
    ifc.out_ready = 1'b0;
    send(32'h0000_0003, 32'd1, 2'b01, model(32'h0000_0003, 32'd1, 2'b01), st);
    send(32'hF000_0000, 32'd2, 2'b10, model(32'hF000_0000, 32'd2, 2'b10), st);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b, required 0", ifc.out_valid); end
    checks++; if (done_cnt !== '0) begin errors++; $display("FAIL midrst_done_cnt: got %0d, required 0", done_cnt); end
    checks++; if (ifc.out_zero !== 1'b1 || ifc.out_res !== 32'h0) begin errors++; $display("FAIL midrst_out_res: got res=%h zero=%b, required res=0 zero=1", ifc.out_res, ifc.out_zero); end
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: out_valid got %b, required 0", ifc.out_valid); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    int unsigned st;
    logic [31:0] a, b;
    do_reset();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      a = $urandom;
      b = $urandom;
      send(a, b, 2'b11, model(a, b, 2'b11), st);
    end
    drain();
    checks++; if (done_cnt !== CNT_W'(1)) begin errors++; $display("FAIL wrap_done_cnt: got %0d, required 1", done_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.in_op     = 2'b00;
    ifc.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_directed();
    test_throughput();
    test_random_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
